// File: rtl/xs_video_pkg.sv
// xs_video_pkg: shared constants and types for the Xain'd Sleena raster timing generator.
//   DEF_*    default raster timing (pixels / lines)
//   CNT_W    width of the H and V counters
//   cnt_t    one counter value
//   hv_pos_t {H,V} raster position pair
package xs_video_pkg;

    localparam int unsigned CNT_W = 9;

    localparam int unsigned DEF_H_TOTAL      = 384;
    localparam int unsigned DEF_HBLANK_START = 256;
    localparam int unsigned DEF_HSYNC_START  = 288;
    localparam int unsigned DEF_HSYNC_END    = 320;
    localparam int unsigned DEF_V_TOTAL      = 272;
    localparam int unsigned DEF_VBLANK_END   = 8;
    localparam int unsigned DEF_VBLANK_START = 248;
    localparam int unsigned DEF_VSYNC_START  = 256;
    localparam int unsigned DEF_VSYNC_END    = 260;
    localparam int unsigned DEF_FIRQ_SHIFT   = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t h;
        cnt_t v;
    } hv_pos_t;

endpackage

// File: rtl/xs_video_timing_if.sv
// xs_video_timing_if: bundle between the raster timing generator and its consumers.
//   Pix_ce, Nmi_en, Firq_en         controls into the generator
//   H_cnt, V_cnt                    current raster position
//   HBlank, VBlank, HSync_n, VSync_n level timing flags
//   Line_pulse, Nmi_pulse, Firq_pulse one-cycle event pulses (clock the IRQ latches)
// master = the generator, slave = the consumer that supplies the enables.
interface xs_video_timing_if;
    import xs_video_pkg::*;

    logic Pix_ce;
    logic Nmi_en;
    logic Firq_en;
    cnt_t H_cnt;
    cnt_t V_cnt;
    logic HBlank;
    logic VBlank;
    logic HSync_n;
    logic VSync_n;
    logic Line_pulse;
    logic Nmi_pulse;
    logic Firq_pulse;

    modport master (
        input  Pix_ce, Nmi_en, Firq_en,
        output H_cnt, V_cnt, HBlank, VBlank, HSync_n, VSync_n,
        output Line_pulse, Nmi_pulse, Firq_pulse
    );

    modport slave (
        output Pix_ce, Nmi_en, Firq_en,
        input  H_cnt, V_cnt, HBlank, VBlank, HSync_n, VSync_n,
        input  Line_pulse, Nmi_pulse, Firq_pulse
    );

endinterface

// File: rtl/xs_mod_counter.sv
// xs_mod_counter: modulo-MODULUS up-counter with clock-enable and synchronous reset.
//   Clk        rising-edge clock
//   Reset      synchronous, active-high; forces the count to 0
//   Ce         count enable
//   Count      registered count
//   Count_nxt  value Count takes on the next edge, so the parent can register
//              flags decoded from it in step with Count
//   Carry      high when this Ce wraps the count from MODULUS-1 to 0
module xs_mod_counter #(
    parameter int unsigned MODULUS = 384,
    parameter int unsigned WIDTH   = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ce,
    output logic [WIDTH-1:0] Count,
    output logic [WIDTH-1:0] Count_nxt,
    output logic             Carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // No carry during reset, so nothing downstream sees a wrap on the forced 0.
    assign Carry = Ce && !Reset && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (Reset) begin
            count_d = '0;
        end else if (Carry) begin
            count_d = '0;
        end else if (Ce) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count     = count_q;
    assign Count_nxt = count_d;

endmodule

// File: rtl/xs_video_timing.sv
// xs_video_timing: raster timing generator for the Xain'd Sleena video board.
//   Clk    rising-edge master clock
//   Reset  synchronous, active-high
//   Vid    xs_video_timing_if.master: Pix_ce/Nmi_en/Firq_en in; counters, blank/sync
//          levels and Line/Nmi/Firq pulses out, all registered.
// Flags are decoded from the counters' next-state values and registered on the same
// edge as the counters, so every flag matches the H_cnt/V_cnt shown with it.
module xs_video_timing
    import xs_video_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned HBLANK_START = DEF_HBLANK_START,
    parameter int unsigned HSYNC_START  = DEF_HSYNC_START,
    parameter int unsigned HSYNC_END    = DEF_HSYNC_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned VBLANK_END   = DEF_VBLANK_END,
    parameter int unsigned VBLANK_START = DEF_VBLANK_START,
    parameter int unsigned VSYNC_START  = DEF_VSYNC_START,
    parameter int unsigned VSYNC_END    = DEF_VSYNC_END,
    parameter int unsigned FIRQ_SHIFT   = DEF_FIRQ_SHIFT
) (
    input  logic              Clk,
    input  logic              Reset,
    xs_video_timing_if.master Vid
);

    localparam cnt_t HB_START  = cnt_t'(HBLANK_START);
    localparam cnt_t HS_START  = cnt_t'(HSYNC_START);
    localparam cnt_t HS_END    = cnt_t'(HSYNC_END);
    localparam cnt_t VB_END    = cnt_t'(VBLANK_END);
    localparam cnt_t VB_START  = cnt_t'(VBLANK_START);
    localparam cnt_t VS_START  = cnt_t'(VSYNC_START);
    localparam cnt_t VS_END    = cnt_t'(VSYNC_END);
    localparam cnt_t FIRQ_MASK = cnt_t'((1 << FIRQ_SHIFT) - 1);

    cnt_t    h_q, h_d, v_q, v_d;
    logic    h_carry, v_carry;
    hv_pos_t pos_d;

    logic hblank_d, vblank_d, hsync_n_d, vsync_n_d, line_d, nmi_d, firq_d;
    logic hblank_q, vblank_q, hsync_n_q, vsync_n_q, line_q, nmi_q, firq_q;

    xs_mod_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (CNT_W)
    ) u_h_cnt (
        .Clk       (Clk),
        .Reset     (Reset),
        .Ce        (Vid.Pix_ce),
        .Count     (h_q),
        .Count_nxt (h_d),
        .Carry     (h_carry)
    );

    xs_mod_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (CNT_W)
    ) u_v_cnt (
        .Clk       (Clk),
        .Reset     (Reset),
        .Ce        (h_carry),
        .Count     (v_q),
        .Count_nxt (v_d),
        .Carry     (v_carry)
    );

    always_comb begin
        pos_d     = '{h: h_d, v: v_d};
        hblank_d  = (pos_d.h >= HB_START);
        vblank_d  = (pos_d.v < VB_END) || (pos_d.v >= VB_START);
        hsync_n_d = !((pos_d.h >= HS_START) && (pos_d.h < HS_END));
        vsync_n_d = !((pos_d.v >= VS_START) && (pos_d.v < VS_END));
        // h_carry is already Pix_ce-qualified and masked by reset, so every pulse
        // falls back to 0 on any edge without a real line wrap.
        line_d    = h_carry;
        nmi_d     = h_carry && (pos_d.v == VB_START) && Vid.Nmi_en;
        firq_d    = h_carry && (pos_d.v >= VB_END) && (pos_d.v < VB_START) &&
                    ((pos_d.v & FIRQ_MASK) == '0) && Vid.Firq_en;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hblank_q  <= 1'b0;
            vblank_q  <= 1'b1;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            line_q    <= 1'b0;
            nmi_q     <= 1'b0;
            firq_q    <= 1'b0;
        end else begin
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            line_q    <= line_d;
            nmi_q     <= nmi_d;
            firq_q    <= firq_d;
        end
    end

    // A frame wrap is only ever a special case of a line wrap.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (!v_carry || h_carry);
        end
    end

    assign Vid.H_cnt      = h_q;
    assign Vid.V_cnt      = v_q;
    assign Vid.HBlank     = hblank_q;
    assign Vid.VBlank     = vblank_q;
    assign Vid.HSync_n    = hsync_n_q;
    assign Vid.VSync_n    = vsync_n_q;
    assign Vid.Line_pulse = line_q;
    assign Vid.Nmi_pulse  = nmi_q;
    assign Vid.Firq_pulse = firq_q;

endmodule

// File: tb/tb_xs_video_timing.sv
// Bench for xs_video_timing. Instance A uses the default raster; instance B keeps the
// default vertical timing with a 24-pixel line so whole frames stay short. A raster
// model (linear pixel index, divided into H and V) predicts every output each cycle.
module tb_xs_video_timing;
    import xs_video_pkg::*;

    localparam int unsigned VT      = 272;
    localparam int unsigned B_HT    = 24;
    localparam int unsigned B_FRAME = B_HT * VT;

    logic Clk;
    logic Reset;

    xs_video_timing_if va ();
    xs_video_timing_if vb ();

    xs_video_timing u_dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .Vid   (va)
    );

    xs_video_timing #(
        .H_TOTAL      (B_HT),
        .HBLANK_START (16),
        .HSYNC_START  (18),
        .HSYNC_END    (20)
    ) u_dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .Vid   (vb)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: linear pixel index within the frame, expected pulses.
    int unsigned pos [2];
    bit          exp_lp [2];
    bit          exp_nmi [2];
    bit          exp_firq [2];

    // Observation statistics.
    int cyc, nmi_n, nmi_v, nmi_h, vs_n, vs_min, vs_max, wrap_n, wrap_cyc, pw_bad;
    int hb_rise, hs_n, hs_min, hs_max, lpa_n, lpa_v, lpa_h;
    int firq_lines [$];
    bit hb_prev, lp_prev, nmi_prev, firq_prev;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int unsigned h_total(input int k);
        return (k == 0) ? 384 : B_HT;
    endfunction

    function automatic int unsigned hb_start(input int k);
        return (k == 0) ? 256 : 16;
    endfunction

    function automatic int unsigned hs_start(input int k);
        return (k == 0) ? 288 : 18;
    endfunction

    function automatic int unsigned hs_end(input int k);
        return (k == 0) ? 320 : 20;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit rst, input bit ce, input bit nmi,
                              input bit firq);
        int unsigned h, v;
        exp_lp[k]   = 1'b0;
        exp_nmi[k]  = 1'b0;
        exp_firq[k] = 1'b0;
        if (rst) begin
            pos[k] = 0;
        end else if (ce) begin
            pos[k]      = (pos[k] + 1) % (h_total(k) * VT);
            h           = pos[k] % h_total(k);
            v           = pos[k] / h_total(k);
            exp_lp[k]   = (h == 0);
            exp_nmi[k]  = (h == 0) && (v == 248) && nmi;
            exp_firq[k] = (h == 0) && (v >= 8) && (v < 248) && (v % 16 == 0) && firq;
        end
    endtask

    task automatic cmp_outs(input string p, input int k, input int h_o, input int v_o,
                            input bit hb, input bit vbk, input bit hs, input bit vs,
                            input bit lp, input bit np, input bit fp);
        int unsigned h, v;
        h = pos[k] % h_total(k);
        v = pos[k] / h_total(k);
        check({p, ".H_cnt"}, h_o, int'(h));
        check({p, ".V_cnt"}, v_o, int'(v));
        check({p, ".HBlank"}, int'(hb), int'(h >= hb_start(k)));
        check({p, ".VBlank"}, int'(vbk), int'((v < 8) || (v >= 248)));
        check({p, ".HSync_n"}, int'(hs), int'(!((h >= hs_start(k)) && (h < hs_end(k)))));
        check({p, ".VSync_n"}, int'(vs), int'(!((v >= 256) && (v < 260))));
        check({p, ".Line_pulse"}, int'(lp), int'(exp_lp[k]));
        check({p, ".Nmi_pulse"}, int'(np), int'(exp_nmi[k]));
        check({p, ".Firq_pulse"}, int'(fp), int'(exp_firq[k]));
    endtask

    task automatic clear_stats();
        cyc = 0; nmi_n = 0; nmi_v = -1; nmi_h = -1; vs_n = 0; vs_min = 999; vs_max = -1;
        wrap_n = 0; wrap_cyc = -1; pw_bad = 0; hb_rise = -1; hs_n = 0; hs_min = 999;
        hs_max = -1; lpa_n = 0; lpa_v = -1; lpa_h = -1;
        firq_lines.delete();
    endtask

    task automatic step(input bit rst, input bit ce, input bit nmi, input bit firq);
        Reset      = rst;
        va.Pix_ce  = ce;
        vb.Pix_ce  = ce;
        va.Nmi_en  = nmi;
        vb.Nmi_en  = nmi;
        va.Firq_en = firq;
        vb.Firq_en = firq;
        @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) model_step(k, rst, ce, nmi, firq);
        cmp_outs("A", 0, int'(va.H_cnt), int'(va.V_cnt), va.HBlank, va.VBlank, va.HSync_n,
                 va.VSync_n, va.Line_pulse, va.Nmi_pulse, va.Firq_pulse);
        cmp_outs("B", 1, int'(vb.H_cnt), int'(vb.V_cnt), vb.HBlank, vb.VBlank, vb.HSync_n,
                 vb.VSync_n, vb.Line_pulse, vb.Nmi_pulse, vb.Firq_pulse);
        cyc++;
        // Instance B: frame-level events.
        if (vb.Nmi_pulse) begin
            nmi_n++;
            nmi_v = int'(vb.V_cnt);
            nmi_h = int'(vb.H_cnt);
        end
        if (vb.Firq_pulse) firq_lines.push_back(int'(vb.V_cnt));
        if (!vb.VSync_n) begin
            vs_n++;
            if (int'(vb.V_cnt) < vs_min) vs_min = int'(vb.V_cnt);
            if (int'(vb.V_cnt) > vs_max) vs_max = int'(vb.V_cnt);
        end
        if (vb.Line_pulse && vb.V_cnt == '0) begin
            wrap_n++;
            wrap_cyc = cyc;
        end
        if ((vb.Line_pulse && lp_prev) || (vb.Nmi_pulse && nmi_prev) ||
            (vb.Firq_pulse && firq_prev)) pw_bad++;
        lp_prev   = vb.Line_pulse;
        nmi_prev  = vb.Nmi_pulse;
        firq_prev = vb.Firq_pulse;
        // Instance A: line-level events.
        if (va.HBlank && !hb_prev) hb_rise = int'(va.H_cnt);
        hb_prev = va.HBlank;
        if (!va.HSync_n) begin
            hs_n++;
            if (int'(va.H_cnt) < hs_min) hs_min = int'(va.H_cnt);
            if (int'(va.H_cnt) > hs_max) hs_max = int'(va.H_cnt);
        end
        if (va.Line_pulse) begin
            lpa_n++;
            lpa_v = int'(va.V_cnt);
            lpa_h = int'(va.H_cnt);
        end
    endtask

    initial begin
        int unsigned nxt;
        int          firq_sum;

        Reset = 1'b1;
        clear_stats();

        // Reset held 3 cycles with Pix_ce high.
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst.H_cnt", int'(va.H_cnt), 0);
        check("rst.V_cnt", int'(va.V_cnt), 0);
        check("rst.VBlank", int'(va.VBlank), 1);
        check("rst.HBlank", int'(va.HBlank), 0);
        check("rst.HSync_n", int'(va.HSync_n), 1);
        check("rst.VSync_n", int'(va.VSync_n), 1);
        check("rst.pulses", int'({va.Line_pulse, va.Nmi_pulse, va.Firq_pulse}), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("first_ce.H_cnt", int'(va.H_cnt), 1);

        // One full default line.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        clear_stats();
        repeat (384) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("line.hblank_rise_h", hb_rise, 256);
        check("line.hsync_low_n", hs_n, 32);
        check("line.hsync_low_min", hs_min, 288);
        check("line.hsync_low_max", hs_max, 319);
        check("line.pulse_n", lpa_n, 1);
        check("line.pulse_v", lpa_v, 1);
        check("line.pulse_h", lpa_h, 0);

        // Full frame on B, both enables high.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        clear_stats();
        repeat (B_FRAME) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("frame.nmi_n", nmi_n, 1);
        check("frame.nmi_v", nmi_v, 248);
        check("frame.nmi_h", nmi_h, 0);
        check("frame.firq_n", firq_lines.size(), 15);
        foreach (firq_lines[i]) check("frame.firq_v", firq_lines[i], 16 * (i + 1));
        check("frame.vsync_cycles", vs_n, 4 * int'(B_HT));
        check("frame.vsync_min_v", vs_min, 256);
        check("frame.vsync_max_v", vs_max, 259);
        check("frame.end_h", int'(vb.H_cnt), 0);
        check("frame.end_v", int'(vb.V_cnt), 0);

        // Enable gating: Nmi_en low only on the edge into (0,248); Firq_en low over line 32.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < int'(B_FRAME); i++) begin
            nxt = pos[1] + 1;
            step(1'b0, 1'b1, nxt != 248 * B_HT, (nxt / B_HT) != 32);
        end
        firq_sum = 0;
        foreach (firq_lines[i]) firq_sum += firq_lines[i];
        check("gate.nmi_n", nmi_n, 0);
        check("gate.firq_n", firq_lines.size(), 14);
        check("gate.firq_sum", firq_sum, 1920 - 32);

        // Pix_ce pattern 1,0,0: one B frame takes 3*B_FRAME clocks.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < 3 * int'(B_FRAME); i++) step(1'b0, (i % 3) == 0, 1'b1, 1'b1);
        // The last Pix_ce (the wrap to (0,0)) lands on clock 3*(B_FRAME-1)+1.
        check("gap.wrap_n", wrap_n, 1);
        check("gap.wrap_cyc", wrap_cyc, 3 * (int'(B_FRAME) - 1) + 1);
        check("gap.pulse_width", pw_bad, 0);
        check("gap.nmi_n", nmi_n, 1);
        check("gap.firq_n", firq_lines.size(), 15);

        // Mid-frame reset on B at (10,150).
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (150 * B_HT + 10) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("mid.pre_h", int'(vb.H_cnt), 10);
        check("mid.pre_v", int'(vb.V_cnt), 150);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid.rst_h", int'(vb.H_cnt), 0);
        check("mid.rst_v", int'(vb.V_cnt), 0);
        check("mid.rst_line_pulse", int'(vb.Line_pulse), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("mid.first_ce_h", int'(vb.H_cnt), 1);

        // Random Pix_ce, enables and occasional resets against the model.
        for (int i = 0; i < 5000; i++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
